// File: rtl/fabric_cfg_pkg.sv
// Shared constants, address-word field positions and FSM encoding for the
// configuration frame sequencer.
package fabric_cfg_pkg;

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

  localparam int ADDR_COL_MSB   = 31;
  localparam int ADDR_COL_LSB   = 24;
  localparam int ADDR_FRAME_MSB = 4;
  localparam int ADDR_FRAME_LSB = 0;

  localparam int COL_W   = ADDR_COL_MSB - ADDR_COL_LSB + 1;
  localparam int FRAME_W = ADDR_FRAME_MSB - ADDR_FRAME_LSB + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    DATA   = 2'd2,
    STROBE = 2'd3
  } cfg_state_t;

  // True when the (column, frame) pair addresses an existing strobe bit.
  function automatic logic addr_in_range(input logic [COL_W-1:0]   col,
                                         input logic [FRAME_W-1:0] frame,
                                         input int                 num_cols,
                                         input int                 num_frames);
    return (int'(col) < num_cols) && (int'(frame) < num_frames);
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decoder: turns a latched (column, frame) address into the
// FrameStrobe vector; the async clear drops the strobe the moment reset asserts.
module frame_strobe_decoder
  import fabric_cfg_pkg::*;
#(
  parameter int NumColumns      = 4,
  parameter int MaxFramesPerCol = 20
) (
  input  logic                                  CLK,
  input  logic                                  resetn,
  input  logic [COL_W-1:0]                      col,
  input  logic [FRAME_W-1:0]                    frame,
  input  logic                                  en,
  output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

  logic [NumColumns*MaxFramesPerCol-1:0] strobe_d;

  // Out-of-range addresses decode to nothing, so at most one bit can be set.
  always_comb begin
    strobe_d = '0;
    for (int c = 0; c < NumColumns; c++) begin
      for (int f = 0; f < MaxFramesPerCol; f++) begin
        strobe_d[c*MaxFramesPerCol+f] = en && (int'(col) == c) && (int'(frame) == f);
      end
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) strobe <= '0;
    else         strobe <= strobe_d;
  end

endmodule

// File: rtl/frame_config_sequencer.sv
// Bitstream-to-frame feeder: loads one FrameData word per row, then pulses a
// single FrameStrobe bit so the addressed column latches the frame.
module frame_config_sequencer
  import fabric_cfg_pkg::*;
#(
  parameter int NumRows         = 4,
  parameter int NumColumns      = 4,
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int StrobeCycles    = 2
) (
  input  logic                                  CLK,
  input  logic                                  resetn,
  input  logic [FrameBitsPerRow-1:0]            s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  err,
  output logic [15:0]                           frames_done
);

  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int StrW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);
  localparam logic [StrW-1:0] LastStr = StrW'(StrobeCycles - 1);

  cfg_state_t         state, next_state;
  logic [RowW-1:0]    row_cnt;
  logic [StrW-1:0]    strb_cnt;
  logic [COL_W-1:0]   addr_col;
  logic [FRAME_W-1:0] addr_frame;
  logic               frame_ok;
  logic               accept, is_sync, is_desync, word_ok, strobe_en;

  assign accept    = s_valid && s_ready;
  assign is_sync   = (s_data == SYNC_WORD);
  assign is_desync = (s_data == DESYNC_WORD);
  assign word_ok   = addr_in_range(s_data[ADDR_COL_MSB:ADDR_COL_LSB],
                                   s_data[ADDR_FRAME_MSB:ADDR_FRAME_LSB],
                                   NumColumns, MaxFramesPerCol);

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (accept && is_sync) next_state = ADDR;
      ADDR:   if (accept) next_state = is_desync ? IDLE : DATA;
      DATA:   if (accept && row_cnt == LastRow) next_state = frame_ok ? STROBE : ADDR;
      STROBE: if (strb_cnt == LastStr) next_state = ADDR;
      default: next_state = IDLE;
    endcase
  end

  // Strobe register follows the state register, so the strobe is high exactly in STROBE.
  assign strobe_en = (next_state == STROBE);

  // NOTE: every register here uses <= so all of them sample pre-edge values.
  // NOTE: FrameData is flop-based, so it can and does take a reset value; it is not a memory macro.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      frames_done <= '0;
      row_cnt     <= '0;
      strb_cnt    <= '0;
      addr_col    <= '0;
      addr_frame  <= '0;
      frame_ok    <= 1'b0;
      FrameData   <= '0;
    end else begin
      state   <= next_state;
      s_ready <= (next_state != STROBE);
      busy    <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (accept && is_sync) begin
            err         <= 1'b0;
            frames_done <= '0;
          end
        end
        ADDR: begin
          if (accept && !is_desync) begin
            addr_col   <= s_data[ADDR_COL_MSB:ADDR_COL_LSB];
            addr_frame <= s_data[ADDR_FRAME_MSB:ADDR_FRAME_LSB];
            row_cnt    <= '0;
            frame_ok   <= word_ok;
            if (!word_ok) err <= 1'b1;
          end
        end
        DATA: begin
          if (accept) begin
            for (int r = 0; r < NumRows; r++) begin
              if (row_cnt == RowW'(r)) FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
            end
            row_cnt  <= row_cnt + 1'b1;
            strb_cnt <= '0;
          end
        end
        STROBE: begin
          strb_cnt <= strb_cnt + 1'b1;
          if (strb_cnt == LastStr) frames_done <= frames_done + 16'd1;
        end
        default: ;
      endcase
    end
  end

  frame_strobe_decoder #(
    .NumColumns     (NumColumns),
    .MaxFramesPerCol(MaxFramesPerCol)
  ) u_strobe_decoder (
    .CLK   (CLK),
    .resetn(resetn),
    .col   (addr_col),
    .frame (addr_frame),
    .en    (strobe_en),
    .strobe(FrameStrobe)
  );

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Scoreboard bench: frame-level model predicts strobes and register state;
// a negedge monitor pops expectations whenever a strobe pulse appears.
`timescale 1ns/1ps
module tb_frame_config_sequencer;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int NF = 20;
  localparam int W  = 32;
  localparam int SC = 2;
  localparam int SW = NC * NF;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  logic          CLK = 1'b0;
  logic          resetn;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic [NR*W-1:0] FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          busy, err;
  logic [15:0]   frames_done;

  always #5 CLK = ~CLK;

  frame_config_sequencer #(
    .NumRows(NR), .NumColumns(NC), .MaxFramesPerCol(NF),
    .FrameBitsPerRow(W), .StrobeCycles(SC)
  ) dut (
    .CLK(CLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .err(err),
    .frames_done(frames_done)
  );

  typedef struct {
    int              bit_idx;
    logic [NR*W-1:0] data;
    int              start_cyc;
    logic [15:0]     done_after;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Frame-level reference state
  logic [W-1:0] exp_rows [NR];
  bit           synced;
  bit           exp_err;
  logic [15:0]  exp_done;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [NR*W-1:0] flat_rows();
    logic [NR*W-1:0] v;
    for (int r = 0; r < NR; r++) v[r*W +: W] = exp_rows[r];
    return v;
  endfunction

  task automatic send(input logic [31:0] w, input bit gaps, output int acc_edge);
    acc_edge = -1;
    for (int tries = 0; tries < 400; tries++) begin
      @(negedge CLK);
      if (gaps && $urandom_range(1) == 0) begin
        s_valid = 1'b0;
        s_data  = $urandom;
      end else begin
        s_valid = 1'b1;
        s_data  = w;
        if (s_ready) begin
          acc_edge = cyc + 1;
          return;
        end
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: got no s_ready want accept of %0h", w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      s_valid = 1'b0;
    end
  endtask

  task automatic do_sync();
    int acc;
    send(SYNC, 1'b0, acc);
    synced   = 1'b1;
    exp_err  = 1'b0;
    exp_done = '0;
  endtask

  // One frame: address word then NR data words; base!=0 gives base+row data.
  task automatic send_frame(input logic [7:0] col, input logic [4:0] fr,
                            input bit gaps, input logic [31:0] base);
    logic [31:0] d;
    int          acc;
    exp_t        e;
    send({col, 19'($urandom), fr}, gaps, acc);
    for (int r = 0; r < NR; r++) begin
      d = (base != 0) ? base + 32'(r) : 32'($urandom);
      if (d == SYNC) d = d ^ 32'h1;
      send(d, gaps, acc);
      if (synced) exp_rows[r] = d;
    end
    if (synced) begin
      if (int'(col) < NC && int'(fr) < NF) begin
        exp_done    = exp_done + 16'd1;
        e.bit_idx    = int'(col) * NF + int'(fr);
        e.data       = flat_rows();
        e.start_cyc  = acc;
        e.done_after = exp_done;
        exp_q.push_back(e);
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_data"}, FrameData, flat_rows());
    check({tag, "_err"}, err, exp_err);
    check({tag, "_done"}, frames_done, exp_done);
    check({tag, "_busy"}, busy, synced);
    check({tag, "_strobe"}, FrameStrobe, '0);
  endtask

  // Monitor
  bit              in_strb   = 1'b0;
  bit              have_cur  = 1'b0;
  int              width     = 0;
  int              since_rst = 0;
  exp_t            cur;
  logic [SW-1:0]   held_strb;
  logic [NR*W-1:0] held_data;
  logic [SW-1:0]   exp_vec;

  always @(negedge CLK) begin
    if (!resetn) begin
      in_strb   = 1'b0;
      since_rst = 0;
    end else begin
      since_rst++;
      check("ready_vs_strobe", s_ready, (FrameStrobe == '0));
      if (FrameStrobe != '0) begin
        check("strobe_onehot", $onehot0(FrameStrobe), 1'b1);
        if (!in_strb) begin
          in_strb   = 1'b1;
          width     = 1;
          held_strb = FrameStrobe;
          held_data = FrameData;
          if (exp_q.size() == 0) begin
            have_cur = 1'b0;
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe: got %0h want none", FrameStrobe);
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            exp_vec  = '0;
            exp_vec[cur.bit_idx] = 1'b1;
            check("strobe_bit", FrameStrobe, exp_vec);
            check("strobe_data", FrameData, cur.data);
            check("strobe_start", cyc, cur.start_cyc);
          end
        end else begin
          width++;
          check("strobe_hold", FrameStrobe, held_strb);
          check("data_stable", FrameData, held_data);
        end
      end else if (in_strb) begin
        in_strb = 1'b0;
        check("strobe_len", width, SC);
        check("data_after", FrameData, held_data);
        if (have_cur) check("frames_done", frames_done, cur.done_after);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int acc;
    resetn  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    synced  = 1'b0;
    exp_err = 1'b0;
    exp_done = '0;
    for (int r = 0; r < NR; r++) exp_rows[r] = '0;

    // Reset values
    repeat (2) @(negedge CLK);
    check("rst_data", FrameData, '0);
    check("rst_strobe", FrameStrobe, '0);
    check("rst_ready", s_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_done", frames_done, 16'd0);
    #2 resetn = 1'b1;
    idle(2);
    check("idle_ready", s_ready, 1'b1);
    check("idle_busy", busy, 1'b0);

    // Directed frame: column 1 frame 3 -> bit 23
    do_sync();
    send_frame(8'd1, 5'd3, 1'b0, 32'hA000_00A0);
    idle(8);
    check_state("t1");

    // Out-of-range column: data consumed, no strobe, err set
    send_frame(8'd7, 5'd0, 1'b0, 32'h0);
    idle(8);
    check_state("t2");

    // Random frames with ~50% valid gaps
    for (int i = 0; i < 10; i++) begin
      send_frame(8'($urandom_range(NC - 1)), 5'($urandom_range(NF - 1)), 1'b1, 32'h0);
    end
    idle(8);
    check_state("t3");

    // Reset during the first strobe cycle clears the strobe immediately
    send_frame(8'd2, 5'd5, 1'b0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (FrameStrobe != '0) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL reset_strobe_wait: got no strobe want strobe");
    end
    #2 resetn = 1'b0;
    s_valid = 1'b0;
    #1;
    check("async_clear_strobe", FrameStrobe, '0);
    check("async_clear_busy", busy, 1'b0);
    check("async_clear_ready", s_ready, 1'b0);
    synced   = 1'b0;
    exp_err  = 1'b0;
    exp_done = '0;
    for (int r = 0; r < NR; r++) exp_rows[r] = '0;
    repeat (2) @(negedge CLK);
    #2 resetn = 1'b1;
    idle(2);
    send_frame(8'd0, 5'd1, 1'b0, 32'h0);
    idle(8);
    check_state("t4");

    // DESYNC, unsynced frame, then SYNC clears err and frames_done
    do_sync();
    send_frame(8'd9, 5'd0, 1'b0, 32'h0);
    send_frame(8'd0, 5'd20, 1'b1, 32'h0);
    send_frame(8'd0, 5'd0, 1'b1, 32'h0);
    idle(8);
    check_state("t5a");
    send(DESYNC, 1'b0, acc);
    synced = 1'b0;
    idle(4);
    check_state("t5b");
    send_frame(8'd1, 5'd1, 1'b0, 32'h0);
    idle(8);
    check_state("t5c");
    do_sync();
    idle(4);
    check_state("t5d");
    send_frame(8'd3, 5'd19, 1'b0, 32'h0);
    idle(8);
    check_state("t5e");

    idle(4);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
